// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO state.
// Results are computed at accept and committed after a fixed latency.
module e_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ARI1_E,
  input  logic [31:0] ARI2_E,
  input  logic [3:0]  MDOP,
  input  logic        START,
  output logic        BUSY,
  output logic [31:0] MDOUT_E
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic        acc;
  logic [63:0] prod_s, prod_u;
  logic [31:0] ua, ub, uq, ur;
  logic [31:0] sq, sr, dq, dr;

  assign acc = START && !busy_q && (cnt_q == 4'd0);

  assign prod_s = {{32{ARI1_E[31]}}, ARI1_E} * {{32{ARI2_E[31]}}, ARI2_E};
  assign prod_u = {32'd0, ARI1_E} * {32'd0, ARI2_E};

  // Signed divide via magnitudes: avoids host overflow on MIN/-1
  always_comb begin
    ua = ARI1_E[31] ? (~ARI1_E + 32'd1) : ARI1_E;
    ub = ARI2_E[31] ? (~ARI2_E + 32'd1) : ARI2_E;
    uq = 32'd0;
    ur = 32'd0;
    if (ub != 32'd0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    sq = (ARI1_E[31] ^ ARI2_E[31]) ? (~uq + 32'd1) : uq;
    sr = ARI1_E[31] ? (~ur + 32'd1) : ur;
    dq = 32'd0;
    dr = 32'd0;
    if (ARI2_E != 32'd0) begin
      dq = ARI1_E / ARI2_E;
      dr = ARI1_E % ARI2_E;
    end
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    cnt_d = cnt_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (acc) begin
      unique case (MDOP)
        OP_MULT: begin
          phi_d = prod_s[63:32];
          plo_d = prod_s[31:0];
          cnt_d = 4'd5;
        end
        OP_MULTU: begin
          phi_d = prod_u[63:32];
          plo_d = prod_u[31:0];
          cnt_d = 4'd5;
        end
        OP_DIV, OP_DIVU: begin
          // Divide by zero re-commits the current HI/LO
          if (ARI2_E == 32'd0) begin
            phi_d = hi_q;
            plo_d = lo_q;
          end else if (MDOP == OP_DIV) begin
            phi_d = sr;
            plo_d = sq;
          end else begin
            phi_d = dr;
            plo_d = dq;
          end
          cnt_d = 4'd10;
        end
        OP_MTHI: hi_d = ARI1_E;
        OP_MTLO: lo_d = ARI1_E;
        default: ;
      endcase
    end
    busy_d = (cnt_d != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      phi_q  <= 32'd0;
      plo_q  <= 32'd0;
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    MDOUT_E = 32'd0;
    if (MDOP == OP_MFHI) MDOUT_E = hi_q;
    else if (MDOP == OP_MFLO) MDOUT_E = lo_q;
  end

  assign BUSY = busy_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, results, reset abort.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ARI1_E, ARI2_E;
  logic [3:0]  MDOP;
  logic        START;
  logic        BUSY;
  logic [31:0] MDOUT_E;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mhi, mlo;

  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2;
  localparam logic [3:0] DIV = 4'd3, DIVU = 4'd4, MFHI = 4'd5;
  localparam logic [3:0] MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk(clk), .reset(reset),
    .ARI1_E(ARI1_E), .ARI2_E(ARI2_E),
    .MDOP(MDOP), .START(START),
    .BUSY(BUSY), .MDOUT_E(MDOUT_E)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] ehi,
                    input logic [31:0] elo);
    START = 1'b0;
    MDOP = MFHI; #1;
    chk({tag, ".hi"}, MDOUT_E, ehi);
    MDOP = MFLO; #1;
    chk({tag, ".lo"}, MDOUT_E, elo);
    chk({tag, ".busy"}, {31'd0, BUSY}, 32'd0);
  endtask

  // Start an op, scramble operands while busy and try an ignored START.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    MDOP = op; START = 1'b1; ARI1_E = a; ARI2_E = b;
    tick();
    for (int k = 1; k <= n; k++) begin
      ARI1_E = $urandom; ARI2_E = $urandom;
      START = 1'b1;
      MDOP = (k == 3) ? MULT : MFHI;
      #1;
      chk($sformatf("%s.busy%0d", tag, k), {31'd0, BUSY}, 32'd1);
      if (k != 3) chk($sformatf("%s.old%0d", tag, k), MDOUT_E, mhi);
      tick();
    end
    rd(tag, ehi, elo);
    mhi = ehi; mlo = elo;
  endtask

  initial begin
    reset = 1'b1; START = 1'b0; MDOP = NONE;
    ARI1_E = 32'd0; ARI2_E = 32'd0;
    mhi = 32'd0; mlo = 32'd0;
    tick(); tick();
    reset = 1'b0;
    rd("reset", 32'd0, 32'd0);

    run_op("mult", MULT, 32'hFFFFFFFE, 32'd3, 5,
           32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", MULTU, 32'hFFFFFFFF, 32'd2, 5,
           32'h00000001, 32'hFFFFFFFE);
    run_op("div", DIV, 32'hFFFFFFF9, 32'd2, 10,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divovf", DIV, 32'h80000000, 32'hFFFFFFFF, 10,
           32'h00000000, 32'h80000000);
    run_op("divneg", DIV, 32'd7, 32'hFFFFFFFE, 10,
           32'h00000001, 32'hFFFFFFFD);
    run_op("divu", DIVU, 32'd100, 32'd7, 10,
           32'h00000002, 32'h0000000E);

    MDOP = MTHI; START = 1'b1; ARI1_E = 32'h11; tick();
    MDOP = MTLO; START = 1'b1; ARI1_E = 32'h22; tick();
    rd("mtx", 32'h11, 32'h22);
    mhi = 32'h11; mlo = 32'h22;
    run_op("divu0", DIVU, 32'd7, 32'd0, 10, 32'h11, 32'h22);

    MDOP = MTHI; START = 1'b1; ARI1_E = 32'h12345678; tick();
    rd("mthi", 32'h12345678, 32'h22);

    MDOP = MFLO; START = 1'b1; ARI1_E = 32'hDEAD; tick();
    MDOP = NONE; START = 1'b1; tick();
    rd("nostate", 32'h12345678, 32'h22);

    // Abort in the third busy cycle
    MDOP = MULT; START = 1'b1; ARI1_E = 32'd3; ARI2_E = 32'd4;
    tick();
    START = 1'b0; MDOP = NONE;
    tick(); tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    rd("abort", 32'd0, 32'd0);
    repeat (8) tick();
    rd("abort.late", 32'd0, 32'd0);

    reset = 1'b1; MDOP = MTLO; START = 1'b1; ARI1_E = 32'd5;
    tick();
    reset = 1'b0;
    rd("rstprio", 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
